// File: rtl/fft_r22sdf_bf.sv
// One radix-2 single-path delay-feedback butterfly stage of an R2^2SDF FFT pipeline.
// BF_TYPE=0 is a plain butterfly (BF I); BF_TYPE=1 adds the trivial -j rotation (BF II).
module fft_r22sdf_bf #(
    parameter int DATA_WIDTH = 25,
    parameter int FFT_N      = 1024,
    parameter int NLOG2      = 10,
    parameter int DELAY_LOG2 = 9,
    parameter int BF_TYPE    = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         data_valid_i,
    input  logic [NLOG2-1:0]             ctr_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         data_valid_o,
    output logic [NLOG2-1:0]             ctr_o,
    output logic signed [DATA_WIDTH:0]   z_re_o,
    output logic signed [DATA_WIDTH:0]   z_im_o
);

    localparam int W1       = DATA_WIDTH + 1;
    localparam int D        = 1 << DELAY_LOG2;
    localparam int CTR_BACK = FFT_N - D;

    logic                 s;
    logic                 rot;
    logic                 primed;
    logic signed [W1-1:0] ext_re, ext_im;
    logic signed [W1-1:0] x_re, x_im;
    logic signed [W1-1:0] m_re, m_im;
    logic signed [W1-1:0] push_re, push_im;
    logic signed [W1-1:0] out_re, out_im;

    assign s      = ctr_i[DELAY_LOG2];
    assign ext_re = {x_re_i[DATA_WIDTH-1], x_re_i};
    assign ext_im = {x_im_i[DATA_WIDTH-1], x_im_i};

    generate
        if (BF_TYPE == 1) begin : g_rot
            assign rot = s & ctr_i[DELAY_LOG2+1];
        end else begin : g_no_rot
            assign rot = 1'b0;
        end
    endgenerate

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        x_re = ext_re;
        x_im = ext_im;
        if (rot) begin
            x_re = ext_im;
            x_im = -ext_re;
        end
        push_re = x_re;
        push_im = x_im;
        out_re  = m_re;
        out_im  = m_im;
        if (s) begin
            push_re = m_re - x_re;
            push_im = m_im - x_im;
            out_re  = m_re + x_re;
            out_im  = m_im + x_im;
        end
    end

    // The sample index low bits address the delay line: the slot read now was written D samples ago.
    generate
        if (DELAY_LOG2 == 0) begin : g_dl_reg
            logic signed [W1-1:0] dl_re, dl_im;

            // NOTE: delay-line storage carries no reset; its contents are never observed before being rewritten.
            always_ff @(posedge clk_i) begin
                if (data_valid_i) begin
                    dl_re <= push_re;
                    dl_im <= push_im;
                end
            end

            assign m_re = dl_re;
            assign m_im = dl_im;
        end else begin : g_dl_ram
            logic signed [W1-1:0]  mem_re [D];
            logic signed [W1-1:0]  mem_im [D];
            logic [DELAY_LOG2-1:0] addr;

            assign addr = ctr_i[DELAY_LOG2-1:0];

            always_ff @(posedge clk_i) begin
                if (data_valid_i) begin
                    mem_re[addr] <= push_re;
                    mem_im[addr] <= push_im;
                end
            end

            assign m_re = mem_re[addr];
            assign m_im = mem_im[addr];
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_o <= 1'b0;
            ctr_o        <= '0;
            z_re_o       <= '0;
            z_im_o       <= '0;
            primed       <= 1'b0;
        end else begin
            data_valid_o <= data_valid_i & (primed | s);
            if (data_valid_i) begin
                z_re_o <= out_re;
                z_im_o <= out_im;
                ctr_o  <= ctr_i + NLOG2'(CTR_BACK);
                if (s) begin
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_r22sdf_bf.sv
// Self-checking bench for fft_r22sdf_bf: single BF I / BF II stages against a butterfly-pair
// model, and a four-stage chain against a frame-level DIF R2^2 model.
module tb_fft_r22sdf_bf;

    typedef logic signed [31:0] word_t;

    logic clk = 1'b0;
    logic rst_n;

    // Shared stimulus for the single-stage DUTs (D=2)
    logic              in_valid;
    logic [3:0]        in_ctr;
    logic signed [9:0] in_re, in_im;

    logic               a_dvo, b_dvo;
    logic [3:0]         a_ctr, b_ctr;
    logic signed [10:0] a_re, a_im, b_re, b_im;

    // Chain: D=8 BF I -> D=4 BF II -> D=2 BF I -> D=1 BF II
    logic               c_valid, s1_v, s2_v, s3_v, s4_v;
    logic [3:0]         c_ctr, s1_c, s2_c, s3_c, s4_c;
    logic signed [7:0]  c_re, c_im;
    logic signed [8:0]  s1_re, s1_im;
    logic signed [9:0]  s2_re, s2_im;
    logic signed [10:0] s3_re, s3_im;
    logic signed [11:0] s4_re, s4_im;

    int    n_cmp, n_bad;
    logic  exp_dvo;
    bit    primed_m;
    int    xr_q[$], xi_q[$];
    int    cx_r[$], cx_i[$];
    word_t qa_c[$], qa_r[$], qa_i[$];
    word_t qb_c[$], qb_r[$], qb_i[$];
    word_t qz_c[$], qz_r[$], qz_i[$];

    always #5 clk = ~clk;

    fft_r22sdf_bf #(.DATA_WIDTH(10), .FFT_N(16), .NLOG2(4), .DELAY_LOG2(1), .BF_TYPE(0)) u_a (
        .clk_i(clk), .rst_n(rst_n), .data_valid_i(in_valid), .ctr_i(in_ctr),
        .x_re_i(in_re), .x_im_i(in_im), .data_valid_o(a_dvo), .ctr_o(a_ctr),
        .z_re_o(a_re), .z_im_o(a_im));

    fft_r22sdf_bf #(.DATA_WIDTH(10), .FFT_N(16), .NLOG2(4), .DELAY_LOG2(1), .BF_TYPE(1)) u_b (
        .clk_i(clk), .rst_n(rst_n), .data_valid_i(in_valid), .ctr_i(in_ctr),
        .x_re_i(in_re), .x_im_i(in_im), .data_valid_o(b_dvo), .ctr_o(b_ctr),
        .z_re_o(b_re), .z_im_o(b_im));

    fft_r22sdf_bf #(.DATA_WIDTH(8), .FFT_N(16), .NLOG2(4), .DELAY_LOG2(3), .BF_TYPE(0)) u_c1 (
        .clk_i(clk), .rst_n(rst_n), .data_valid_i(c_valid), .ctr_i(c_ctr),
        .x_re_i(c_re), .x_im_i(c_im), .data_valid_o(s1_v), .ctr_o(s1_c),
        .z_re_o(s1_re), .z_im_o(s1_im));

    fft_r22sdf_bf #(.DATA_WIDTH(9), .FFT_N(16), .NLOG2(4), .DELAY_LOG2(2), .BF_TYPE(1)) u_c2 (
        .clk_i(clk), .rst_n(rst_n), .data_valid_i(s1_v), .ctr_i(s1_c),
        .x_re_i(s1_re), .x_im_i(s1_im), .data_valid_o(s2_v), .ctr_o(s2_c),
        .z_re_o(s2_re), .z_im_o(s2_im));

    fft_r22sdf_bf #(.DATA_WIDTH(10), .FFT_N(16), .NLOG2(4), .DELAY_LOG2(1), .BF_TYPE(0)) u_c3 (
        .clk_i(clk), .rst_n(rst_n), .data_valid_i(s2_v), .ctr_i(s2_c),
        .x_re_i(s2_re), .x_im_i(s2_im), .data_valid_o(s3_v), .ctr_o(s3_c),
        .z_re_o(s3_re), .z_im_o(s3_im));

    fft_r22sdf_bf #(.DATA_WIDTH(11), .FFT_N(16), .NLOG2(4), .DELAY_LOG2(0), .BF_TYPE(1)) u_c4 (
        .clk_i(clk), .rst_n(rst_n), .data_valid_i(s3_v), .ctr_i(s3_c),
        .x_re_i(s3_re), .x_im_i(s3_im), .data_valid_o(s4_v), .ctr_o(s4_c),
        .z_re_o(s4_re), .z_im_o(s4_im));

    // Output collectors: every valid output sample is queued in arrival order
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_dvo === 1'b1) begin
                qa_c.push_back(word_t'(a_ctr)); qa_r.push_back(word_t'(a_re)); qa_i.push_back(word_t'(a_im));
            end
            if (b_dvo === 1'b1) begin
                qb_c.push_back(word_t'(b_ctr)); qb_r.push_back(word_t'(b_re)); qb_i.push_back(word_t'(b_im));
            end
            if (s4_v === 1'b1) begin
                qz_c.push_back(word_t'(s4_c)); qz_r.push_back(word_t'(s4_re)); qz_i.push_back(word_t'(s4_im));
            end
        end
    end

    task automatic check(input string tag, input logic signed [63:0] observed,
                         input logic signed [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int rnd10();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // Butterfly-pair model: within each 2D block, a_k pairs with b_k = x[base+D+k];
    // slot k gets a+b, slot D+k gets a-b, with b rotated by -j where the t bit is set.
    function automatic void bf_model(input int dl, input int bft, input int xr[$], input int xi[$],
                                     output int yr[$], output int yi[$]);
        int d;
        d  = 1 << dl;
        yr = {};
        yi = {};
        for (int j = 0; j < xr.size() - d; j++) begin
            int base, ia, ib, ar, ai, br, bi, tmp;
            base = j - (j % (2 * d));
            ia   = base + (j % d);
            ib   = ia + d;
            ar = xr[ia]; ai = xi[ia]; br = xr[ib]; bi = xi[ib];
            if (bft == 1 && ((ib >> (dl + 1)) & 1) == 1) begin
                tmp = br; br = bi; bi = -tmp;
            end
            if ((j % (2 * d)) < d) begin
                yr.push_back(ar + br); yi.push_back(ai + bi);
            end else begin
                yr.push_back(ar - br); yi.push_back(ai - bi);
            end
        end
    endfunction

    function automatic int bitrev4(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (((k >> i) & 1) == 1) r |= 1 << (3 - i);
        return r;
    endfunction

    task automatic cmp_stream(input string tag, input word_t qc[$], input word_t qr[$], input word_t qi[$],
                              input int dl, input int bft);
        int yr[$], yi[$];
        int n;
        bf_model(dl, bft, xr_q, xi_q, yr, yi);
        check({tag, "_count"}, qr.size(), yr.size());
        n = (qr.size() < yr.size()) ? qr.size() : yr.size();
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_ctr[%0d]", tag, j), qc[j], j % 16);
            check($sformatf("%s_re[%0d]", tag, j), qr[j], yr[j]);
            check($sformatf("%s_im[%0d]", tag, j), qi[j], yi[j]);
        end
    endtask

    // One clock of shared stimulus; first confirms data_valid_o for the previous step
    task automatic step(input bit v, input int c, input int re, input int im);
        @(negedge clk);
        check("a_valid_o", a_dvo, exp_dvo);
        check("b_valid_o", b_dvo, exp_dvo);
        in_valid = v;
        in_ctr   = c[3:0];
        in_re    = re[9:0];
        in_im    = im[9:0];
        if (v) begin
            xr_q.push_back(re);
            xi_q.push_back(im);
            exp_dvo = primed_m || c[1];
            if (c[1]) primed_m = 1'b1;
        end else begin
            exp_dvo = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 15)), rnd10(), rnd10());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        c_valid  = 1'b0;
        @(negedge clk);
        check("rst_a_valid", a_dvo, 0); check("rst_a_ctr", a_ctr, 0);
        check("rst_a_re", a_re, 0);     check("rst_a_im", a_im, 0);
        check("rst_b_valid", b_dvo, 0); check("rst_b_ctr", b_ctr, 0);
        check("rst_b_re", b_re, 0);     check("rst_b_im", b_im, 0);
        @(negedge clk);
        rst_n = 1'b1;
        qa_c = {}; qa_r = {}; qa_i = {};
        qb_c = {}; qb_r = {}; qb_i = {};
        qz_c = {}; qz_r = {}; qz_i = {};
        xr_q = {}; xi_q = {};
        exp_dvo  = 1'b0;
        primed_m = 1'b0;
    endtask

    initial begin
        int ramp_exp[6];
        int fr[16], fi[16], yr[16], yi[16];
        int h, ar, ai, br, bi, tmp, c;

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b1;
        in_valid = 1'b0; in_ctr = '0; in_re = '0; in_im = '0;
        c_valid = 1'b0;  c_ctr = '0;  c_re = '0;  c_im = '0;
        exp_dvo = 1'b0;  primed_m = 1'b0;
        ramp_exp = '{4, 6, -2, -2, 12, 14};

        // Reset state, then gap-free ramp
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, i % 16, i + 1, 0);
        idle(3);
        cmp_stream("ramp_a", qa_c, qa_r, qa_i, 1, 0);
        cmp_stream("ramp_b", qb_c, qb_r, qb_i, 1, 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("ramp_spec_ctr%0d", k), qa_c[k], k);
            check($sformatf("ramp_spec_re%0d", k), qa_r[k], ramp_exp[k]);
        end

        // Same ramp with random gaps; outputs must match the gap-free model
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) step(1'b0, int'($urandom_range(0, 15)), rnd10(), rnd10());
            step(1'b1, i % 16, i + 1, 0);
        end
        idle(3);
        cmp_stream("gap_a", qa_c, qa_r, qa_i, 1, 0);
        cmp_stream("gap_b", qb_c, qb_r, qb_i, 1, 1);

        // BF II rotation
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, i, (i == 4) ? 1 : ((i == 6) ? 5 : 0), 0);
        idle(3);
        cmp_stream("rot_b", qb_c, qb_r, qb_i, 1, 1);
        check("rot_ctr4", qb_c[4], 4);
        check("rot_re4", qb_r[4], 1);
        check("rot_im4", qb_i[4], -5);
        check("rot_re6", qb_r[6], 1);
        check("rot_im6", qb_i[6], 5);

        // Overflow extremes
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, i, (i == 0 || i == 2 || i == 6) ? -512 : 0, 0);
        idle(3);
        cmp_stream("ovf_a", qa_c, qa_r, qa_i, 1, 0);
        cmp_stream("ovf_b", qb_c, qb_r, qb_i, 1, 1);
        check("ovf_a_re0", qa_r[0], -1024);
        check("ovf_a_re2", qa_r[2], 0);
        check("ovf_b_im4", qb_i[4], 512);
        check("ovf_b_im6", qb_i[6], -512);

        // Reset mid-frame, then restart from ctr 0
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i, 50 + i, -7 * i);
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, i, 100 + 3 * i, 20 - i);
        idle(3);
        cmp_stream("rstmid_a", qa_c, qa_r, qa_i, 1, 0);
        cmp_stream("rstmid_b", qb_c, qb_r, qb_i, 1, 1);

        // Random frames with random gaps
        do_reset();
        for (int i = 0; i < 52; i++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, int'($urandom_range(0, 15)), rnd10(), rnd10());
            step(1'b1, i % 16, rnd10(), rnd10());
        end
        idle(3);
        cmp_stream("rand_a", qa_c, qa_r, qa_i, 1, 0);
        cmp_stream("rand_b", qb_c, qb_r, qb_i, 1, 1);

        // Four-stage chain, five random frames (the last one flushes the pipeline)
        do_reset();
        cx_r = {}; cx_i = {};
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                c_valid = 1'b0;
                @(negedge clk);
            end
            c_valid = 1'b1;
            c_ctr   = 4'(i % 16);
            cx_r.push_back(int'($urandom_range(0, 255)) - 128);
            cx_i.push_back(int'($urandom_range(0, 255)) - 128);
            c_re = 8'(cx_r[i]);
            c_im = 8'(cx_i[i]);
        end
        @(negedge clk);
        c_valid = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("chain_count", qz_r.size(), 65);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                fr[i] = cx_r[16 * f + i];
                fi[i] = cx_i[16 * f + i];
            end
            h = 8;
            for (int st = 0; st < 4; st++) begin
                for (int i = 0; i < 16; i++) begin
                    if ((i & h) == 0) begin
                        ar = fr[i]; ai = fi[i]; br = fr[i + h]; bi = fi[i + h];
                        if ((st % 2) == 1 && ((i + h) & (2 * h)) != 0) begin
                            tmp = br; br = bi; bi = -tmp;
                        end
                        fr[i] = ar + br; fi[i] = ai + bi;
                        fr[i + h] = ar - br; fi[i + h] = ai - bi;
                    end
                end
                h = h / 2;
            end
            // Frequency-ordered result; the pipeline emits it in bit-reversed order
            for (int i = 0; i < 16; i++) begin
                yr[bitrev4(i)] = fr[i];
                yi[bitrev4(i)] = fi[i];
            end
            for (int k = 0; k < 16; k++) begin
                c = 16 * f + k;
                check($sformatf("chain_ctr[%0d]", c), qz_c[c], k);
                check($sformatf("chain_re[%0d]", c), qz_r[c], yr[bitrev4(k)]);
                check($sformatf("chain_im[%0d]", c), qz_i[c], yi[bitrev4(k)]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
